des_round_seq: RTL

- Sequencer for the DES round datapath. It owns the S-box lookup stage's handshake: it issues the one-time table-load request and waits for the table-ready flag, then times the S-box enable.
- It steps 16 rounds of expand / S-box / permute / swap and drives the key-schedule shift controls for encrypt or decrypt.
- It sits between the top-level cipher controller (start/done) and the round datapath registers.

---
 rtl/des_round_seq.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/des_round_seq.sv
// DES round sequencer: owns the S-box table-load handshake and steps the
// 16-round expand / S-box / permute / swap schedule. It also drives the
// key-schedule rotation controls for encrypt and decrypt.
// Every output is a flop that is loaded from the next-state decode.

module des_round_seq #(
    parameter int ROUNDS       = 16,
    parameter int SB_HOLD      = 2,
    parameter int INIT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       decrypt,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       tbl_init,
    input  logic       tbl_ready,
    output logic       sb_en,
    output logic       ip_en,
    output logic       key_load,
    output logic       key_step,
    output logic [1:0] key_shift,
    output logic       key_dir,
    output logic       exp_en,
    output logic       perm_en,
    output logic       swap_en,
    output logic       fp_en,
    output logic [4:0] round_num
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_LOAD   = 4'd2,
        S_EXPAND = 4'd3,
        S_SBOX   = 4'd4,
        S_PERM   = 4'd5,
        S_SWAP   = 4'd6,
        S_FINAL  = 4'd7,
        S_DONE   = 4'd8
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] round_q, round_d;
    logic [3:0] sb_cnt_q, sb_cnt_d;
    logic [7:0] wait_q, wait_d;
    logic       tbl_ok_q, tbl_ok_d;
    logic       dir_q, dir_d;
    logic       err_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q;
    logic       tbl_init_q, tbl_init_d;
    logic       sb_en_q, sb_en_d;
    logic       ip_en_q, ip_en_d;
    logic       key_step_q, key_step_d;
    logic [1:0] key_shift_q, key_shift_d;
    logic       key_dir_q, key_dir_d;
    logic       exp_en_q, exp_en_d;
    logic       perm_en_q, perm_en_d;
    logic       swap_en_q, swap_en_d;
    logic       fp_en_q, fp_en_d;

    // Rotation amount for a round. Decrypt applies no rotation in round 1
    // because its first subkey is K16, which equals the freshly loaded C,D.
    function automatic logic [1:0] key_shift_f(input logic [4:0] rnd, input logic dec);
        logic [1:0] s;
        case (rnd)
            5'd1:               s = dec ? 2'd0 : 2'd1;
            5'd2, 5'd9, 5'd16:  s = 2'd1;
            default:            s = 2'd2;
        endcase
        return s;
    endfunction

    // Next-state logic: sequencing, counters, sticky table-ok flag, direction latch.
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        sb_cnt_d = sb_cnt_q;
        wait_d   = wait_q;
        tbl_ok_d = tbl_ok_q;
        dir_d    = dir_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                round_d = 5'd0;
                if (start) begin
                    dir_d  = decrypt;
                    wait_d = 8'd0;
                    if (tbl_ok_q) begin
                        state_d = S_LOAD;
                        round_d = 5'd1;
                    end else begin
                        state_d = S_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                if (tbl_ready) begin
                    tbl_ok_d = 1'b1;
                    state_d  = S_LOAD;
                    round_d  = 5'd1;
                end else if (wait_q == 8'(INIT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_LOAD: begin
                state_d = S_EXPAND;
            end
            S_EXPAND: begin
                sb_cnt_d = 4'd0;
                state_d  = S_SBOX;
            end
            S_SBOX: begin
                if (sb_cnt_q == 4'(SB_HOLD - 1)) begin
                    state_d = S_PERM;
                end else begin
                    sb_cnt_d = sb_cnt_q + 4'd1;
                end
            end
            S_PERM: begin
                if (round_q < 5'(ROUNDS)) begin
                    state_d = S_SWAP;
                end else begin
                    state_d = S_FINAL;
                end
            end
            S_SWAP: begin
                round_d = round_q + 5'd1;
                state_d = S_EXPAND;
            end
            S_FINAL: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                round_d = 5'd0;
                state_d = S_IDLE;
            end
            default: begin
                round_d = 5'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state so the output flops line up with it.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        tbl_init_d  = (state_d == S_INIT);
        sb_en_d     = (state_d == S_SBOX);
        ip_en_d     = (state_d == S_LOAD);
        exp_en_d    = (state_d == S_EXPAND);
        key_step_d  = (state_d == S_EXPAND);
        key_dir_d   = (state_d == S_EXPAND) ? dir_d : 1'b0;
        key_shift_d = (state_d == S_EXPAND) ? key_shift_f(round_d, dir_d) : 2'd0;
        perm_en_d   = (state_d == S_PERM);
        swap_en_d   = (state_d == S_SWAP);
        fp_en_d     = (state_d == S_FINAL);
    end

    // Control state, round/hold/wait counters, table-ok flag and direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            round_q  <= 5'd0;
            sb_cnt_q <= 4'd0;
            wait_q   <= 8'd0;
            tbl_ok_q <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            sb_cnt_q <= sb_cnt_d;
            wait_q   <= wait_d;
            tbl_ok_q <= tbl_ok_d;
            dir_q    <= dir_d;
        end
    end

    // Output registers; reset clears every strobe at once, mid-block included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tbl_init_q  <= 1'b0;
            sb_en_q     <= 1'b0;
            ip_en_q     <= 1'b0;
            key_step_q  <= 1'b0;
            key_shift_q <= 2'd0;
            key_dir_q   <= 1'b0;
            exp_en_q    <= 1'b0;
            perm_en_q   <= 1'b0;
            swap_en_q   <= 1'b0;
            fp_en_q     <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tbl_init_q  <= tbl_init_d;
            sb_en_q     <= sb_en_d;
            ip_en_q     <= ip_en_d;
            key_step_q  <= key_step_d;
            key_shift_q <= key_shift_d;
            key_dir_q   <= key_dir_d;
            exp_en_q    <= exp_en_d;
            perm_en_q   <= perm_en_d;
            swap_en_q   <= swap_en_d;
            fp_en_q     <= fp_en_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign tbl_init  = tbl_init_q;
    assign sb_en     = sb_en_q;
    assign ip_en     = ip_en_q;
    assign key_load  = ip_en_q;
    assign key_step  = key_step_q;
    assign key_shift = key_shift_q;
    assign key_dir   = key_dir_q;
    assign exp_en    = exp_en_q;
    assign perm_en   = perm_en_q;
    assign swap_en   = swap_en_q;
    assign fp_en     = fp_en_q;
    assign round_num = round_q;

endmodule
